// File: rtl/palette_loader_pkg.sv
// Shared memory definitions for the palette loader: the CGB palette
// register addresses and the palette-select byte layout.
package palette_loader_pkg;

    localparam logic [15:0] BCPS_ADDR = 16'hFF68;
    localparam logic [15:0] BCPD_ADDR = 16'hFF69;
    localparam logic [15:0] OCPS_ADDR = 16'hFF6A;
    localparam logic [15:0] OCPD_ADDR = 16'hFF6B;

    // Palette select byte: bit 7 = auto-increment, bit 6 unused, bits 5:0 = index.
    function automatic logic [7:0] cps_value(input logic auto_inc, input logic [5:0] idx);
        return {auto_inc, 1'b0, idx};
    endfunction

endpackage

// File: rtl/palette_loader.sv
// Palette loader: copies COUNT bytes from memory into the BG or OBJ colour
// palette via BCPS/BCPD or OCPS/OCPD, holding the bus between request and
// last access. Build option PALETTE_LOADER_VERIFY_EN adds a per-byte
// readback check that flags the first mismatching palette index.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for I_START
// REQ    | bus requested, waiting for grant
// SETIDX | write palette index to BCPS/OCPS
// RDA    | present source address (read)
// RDC    | hold source address, capture read data
// WR     | write captured byte to BCPD/OCPD
// VRD    | read back BCPD/OCPD (verify build)
// VCAP   | compare readback with written byte (verify build)
// DONE   | one-cycle completion pulse
module palette_loader
    import palette_loader_pkg::*;
(
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_START,
    input  logic        I_TARGET,
    input  logic [15:0] I_SRC_BASE,
    input  logic [5:0]  I_START_INDEX,
    input  logic [6:0]  I_COUNT,
    output logic        O_BUS_REQ,
    input  logic        I_BUS_GNT,
    output logic [15:0] O_MEMBUS_ADDR,
    output logic [7:0]  O_DATA,
    output logic        O_MEMBUS_WE_L,
    input  logic [7:0]  I_DATA,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ERR,
    output logic [5:0]  O_ERR_INDEX
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_REQ    = 4'd1;
    localparam logic [3:0] S_SETIDX = 4'd2;
    localparam logic [3:0] S_RDA    = 4'd3;
    localparam logic [3:0] S_RDC    = 4'd4;
    localparam logic [3:0] S_WR     = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;
`ifdef PALETTE_LOADER_VERIFY_EN
    localparam logic [3:0] S_VRD    = 4'd7;
    localparam logic [3:0] S_VCAP   = 4'd8;
`endif

    logic [3:0]  state, state_nxt;
    logic        target;
    logic [15:0] src_addr;
    logic [5:0]  idx;
    logic [6:0]  remaining;
    logic [7:0]  rdata;
    logic [15:0] ps_addr, pd_addr;

    assign ps_addr = target ? OCPS_ADDR : BCPS_ADDR;
    assign pd_addr = target ? OCPD_ADDR : BCPD_ADDR;

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; every bus state holds while grant is low.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (I_START)   state_nxt = S_REQ;
            S_REQ:    if (I_BUS_GNT) state_nxt = S_SETIDX;
            S_SETIDX: if (I_BUS_GNT) state_nxt = S_RDA;
            S_RDA:    if (I_BUS_GNT) state_nxt = S_RDC;
            S_RDC:    if (I_BUS_GNT) state_nxt = S_WR;
`ifdef PALETTE_LOADER_VERIFY_EN
            S_WR:     if (I_BUS_GNT) state_nxt = S_VRD;
            S_VRD:    if (I_BUS_GNT) state_nxt = S_VCAP;
            S_VCAP:   if (I_BUS_GNT) state_nxt = (remaining == 7'd0) ? S_DONE : S_SETIDX;
`else
            S_WR:     if (I_BUS_GNT) state_nxt = (remaining == 7'd1) ? S_DONE : S_RDA;
`endif
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

`ifdef PALETTE_LOADER_VERIFY_EN
    logic       err;
    logic [5:0] err_idx;
`endif

    // Datapath: latch the job on start, then walk source address, index and down-counter.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            target    <= 1'b0;
            src_addr  <= 16'h0000;
            idx       <= 6'd0;
            remaining <= 7'd0;
            rdata     <= 8'h00;
`ifdef PALETTE_LOADER_VERIFY_EN
            err       <= 1'b0;
            err_idx   <= 6'd0;
`endif
        end else if (state == S_IDLE) begin
            if (I_START) begin
                target    <= I_TARGET;
                src_addr  <= I_SRC_BASE;
                idx       <= I_START_INDEX;
                remaining <= (I_COUNT == 7'd0) ? 7'd64 : I_COUNT;
`ifdef PALETTE_LOADER_VERIFY_EN
                err       <= 1'b0;
                err_idx   <= 6'd0;
`endif
            end
        end else if (I_BUS_GNT) begin
            if (state == S_RDC) rdata <= I_DATA;
            if (state == S_WR) begin
                src_addr  <= src_addr + 16'd1;
                remaining <= remaining - 7'd1;
`ifndef PALETTE_LOADER_VERIFY_EN
                idx       <= idx + 6'd1;
`endif
            end
`ifdef PALETTE_LOADER_VERIFY_EN
            if (state == S_VCAP) begin
                if (!err && (I_DATA != rdata)) begin
                    err     <= 1'b1;
                    err_idx <= idx;
                end
                idx <= idx + 6'd1;
            end
`endif
        end
    end

`ifdef PALETTE_LOADER_VERIFY_EN
    assign O_ERR       = err;
    assign O_ERR_INDEX = err_idx;
`else
    assign O_ERR       = 1'b0;
    assign O_ERR_INDEX = 6'd0;
`endif

    // Output decode; writes are suppressed whenever grant is low.
    always_comb begin
        O_MEMBUS_ADDR = 16'h0000;
        O_DATA        = 8'h00;
        O_MEMBUS_WE_L = 1'b1;
        O_BUS_REQ     = (state != S_IDLE) && (state != S_DONE);
        O_BUSY        = (state != S_IDLE);
        O_DONE        = (state == S_DONE);
        case (state)
            S_SETIDX: begin
                O_MEMBUS_ADDR = ps_addr;
`ifdef PALETTE_LOADER_VERIFY_EN
                O_DATA        = cps_value(1'b0, idx);
`else
                O_DATA        = cps_value(1'b1, idx);
`endif
                O_MEMBUS_WE_L = ~I_BUS_GNT;
            end
            S_RDA, S_RDC: O_MEMBUS_ADDR = src_addr;
            S_WR: begin
                O_MEMBUS_ADDR = pd_addr;
                O_DATA        = rdata;
                O_MEMBUS_WE_L = ~I_BUS_GNT;
            end
`ifdef PALETTE_LOADER_VERIFY_EN
            S_VRD, S_VCAP: O_MEMBUS_ADDR = pd_addr;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_palette_loader.sv
// Bench for palette_loader: memory + CGB palette model, write scoreboard.
// Builds with or without PALETTE_LOADER_VERIFY_EN.
module tb_palette_loader;

    logic        I_CLK = 1'b0;
    logic        I_RESET, I_START, I_TARGET, I_BUS_GNT;
    logic [15:0] I_SRC_BASE;
    logic [5:0]  I_START_INDEX;
    logic [6:0]  I_COUNT;
    logic [7:0]  I_DATA;
    logic        O_BUS_REQ, O_MEMBUS_WE_L, O_BUSY, O_DONE, O_ERR;
    logic [15:0] O_MEMBUS_ADDR;
    logic [7:0]  O_DATA;
    logic [5:0]  O_ERR_INDEX;

    palette_loader dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_START(I_START), .I_TARGET(I_TARGET),
        .I_SRC_BASE(I_SRC_BASE), .I_START_INDEX(I_START_INDEX), .I_COUNT(I_COUNT),
        .O_BUS_REQ(O_BUS_REQ), .I_BUS_GNT(I_BUS_GNT), .O_MEMBUS_ADDR(O_MEMBUS_ADDR),
        .O_DATA(O_DATA), .O_MEMBUS_WE_L(O_MEMBUS_WE_L), .I_DATA(I_DATA),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR), .O_ERR_INDEX(O_ERR_INDEX)
    );

    always #5 I_CLK = ~I_CLK;

`ifdef PALETTE_LOADER_VERIFY_EN
    localparam int CYC_PER_BYTE = 6;
    localparam int FIXED_CYC    = 1;
`else
    localparam int CYC_PER_BYTE = 3;
    localparam int FIXED_CYC    = 2;
`endif
    // Cycle (edges after the start edge) at which byte 2 sits in RDC.
    localparam int BYTE2_RDC = 3 + CYC_PER_BYTE * 2;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t sb[$];
    wr_t e;

    int n_vec = 0;
    int n_mis = 0;
    int done_cnt = 0;

    logic [7:0]  bpal[64];
    logic [7:0]  opal[64];
    logic [5:0]  bidx = 6'd0, oidx = 6'd0;
    logic        binc = 1'b0, oinc = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    bit          corrupt_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] rd_val(input logic [15:0] a);
        if (a == 16'hFF69) return bpal[bidx] ^ ((corrupt_en && bidx == 6'd5) ? 8'hFF : 8'h00);
        if (a == 16'hFF6B) return opal[oidx];
        return src_byte(a);
    endfunction

    // Memory/palette model and write scoreboard, evaluated mid-cycle.
    always @(negedge I_CLK) begin
        I_DATA = rd_val(prev_addr);
        if (O_MEMBUS_WE_L === 1'b0) begin
            if (sb.size() == 0) chk("unexp_wr", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("wr_addr", O_MEMBUS_ADDR, e.a);
                chk("wr_data", O_DATA, e.d);
            end
            case (O_MEMBUS_ADDR)
                16'hFF68: begin bidx = O_DATA[5:0]; binc = O_DATA[7]; end
                16'hFF6A: begin oidx = O_DATA[5:0]; oinc = O_DATA[7]; end
                16'hFF69: begin bpal[bidx] = O_DATA; if (binc) bidx = bidx + 6'd1; end
                16'hFF6B: begin opal[oidx] = O_DATA; if (oinc) oidx = oidx + 6'd1; end
                default: ;
            endcase
        end
        if (O_BUS_REQ === 1'b1 && I_BUS_GNT === 1'b0) chk("frz_we", O_MEMBUS_WE_L, 1);
        if (O_DONE === 1'b1) done_cnt++;
        prev_addr = O_MEMBUS_ADDR;
    end

    task automatic check_idle(input string tag);
        chk({tag, "_req"},  O_BUS_REQ, 0);
        chk({tag, "_we"},   O_MEMBUS_WE_L, 1);
        chk({tag, "_addr"}, O_MEMBUS_ADDR, 0);
        chk({tag, "_data"}, O_DATA, 0);
        chk({tag, "_busy"}, O_BUSY, 0);
        chk({tag, "_done"}, O_DONE, 0);
    endtask

    task automatic run_load(input logic tgt, input logic [15:0] base, input logic [5:0] sidx,
                            input logic [6:0] cnt, input int drop_cyc, input int abort_cyc,
                            input bit poke_start);
        int n, exp_cyc, cyc, done_before;
        bit done, aborted;
        logic [5:0] pi;
        logic [15:0] ps, pd;
        n  = (cnt == 7'd0) ? 64 : int'(cnt);
        ps = tgt ? 16'hFF6A : 16'hFF68;
        pd = tgt ? 16'hFF6B : 16'hFF69;
        exp_cyc = FIXED_CYC + CYC_PER_BYTE * n + ((drop_cyc > 0) ? 5 : 0);
`ifndef PALETTE_LOADER_VERIFY_EN
        sb.push_back('{a: ps, d: {2'b10, sidx}});
`endif
        for (int i = 0; i < n; i++) begin
`ifdef PALETTE_LOADER_VERIFY_EN
            pi = sidx + 6'(i);
            sb.push_back('{a: ps, d: {2'b00, pi}});
`endif
            sb.push_back('{a: pd, d: src_byte(base + 16'(i))});
        end
        done_before = done_cnt;
        @(posedge I_CLK); #1;
        I_TARGET = tgt; I_SRC_BASE = base; I_START_INDEX = sidx; I_COUNT = cnt; I_START = 1'b1;
        @(posedge I_CLK); #1;
        I_START = 1'b0; I_TARGET = ~tgt; I_SRC_BASE = 16'h1234; I_START_INDEX = 6'd33; I_COUNT = 7'd3;
        @(negedge I_CLK);
        chk("err_clr", O_ERR, 0);
        chk("busy_start", O_BUSY, 1);
        cyc = 0; done = 0; aborted = 0;
        while (!done && !aborted) begin
            @(posedge I_CLK); cyc++; #1;
            if (poke_start && cyc == 5) begin I_START = 1'b1; I_TARGET = ~tgt; I_SRC_BASE = 16'h4000; end
            if (poke_start && cyc == 6) I_START = 1'b0;
            if (drop_cyc > 0 && cyc == drop_cyc)     I_BUS_GNT = 1'b0;
            if (drop_cyc > 0 && cyc == drop_cyc + 5) I_BUS_GNT = 1'b1;
            if (abort_cyc > 0 && cyc == abort_cyc)     I_RESET = 1'b1;
            if (abort_cyc > 0 && cyc == abort_cyc + 1) I_RESET = 1'b0;
            @(negedge I_CLK);
            if (drop_cyc > 0 && cyc == drop_cyc) chk("drop_in_rdc", O_MEMBUS_ADDR, base + 16'd2);
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                check_idle("abort");
                aborted = 1;
            end
            if (O_DONE) done = 1;
            if (cyc > 4000) begin
                chk("timeout", cyc, exp_cyc);
                aborted = 1;
            end
        end
        if (abort_cyc > 0) begin
            repeat (3) @(negedge I_CLK);
            chk("abort_no_done", done_cnt, done_before);
            sb.delete();
        end else if (done) begin
            chk("done_cyc", cyc, exp_cyc);
            @(negedge I_CLK);
            check_idle("post_done");
            chk("done_pulses", done_cnt, done_before + 1);
            chk("sb_empty", sb.size(), 0);
            for (int i = 0; i < n; i++) begin
                pi = sidx + 6'(i);
                chk("pal", tgt ? opal[pi] : bpal[pi], src_byte(base + 16'(i)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin bpal[i] = 8'h00; opal[i] = 8'h00; end
        I_RESET = 1'b1; I_START = 1'b0; I_TARGET = 1'b0; I_BUS_GNT = 1'b1;
        I_SRC_BASE = 16'h0; I_START_INDEX = 6'd0; I_COUNT = 7'd0;
        repeat (3) @(posedge I_CLK);
        @(negedge I_CLK);
        check_idle("reset");
        chk("reset_err", O_ERR, 0);
        chk("reset_err_idx", O_ERR_INDEX, 0);
        @(posedge I_CLK); #1 I_RESET = 1'b0;

        run_load(1'b0, 16'hC000, 6'd0,  7'd8, 0, 0, 1'b1);
        run_load(1'b1, 16'hC000, 6'd62, 7'd4, 0, 0, 1'b0);
        run_load(1'b0, 16'hFFFE, 6'd10, 7'd0, 0, 0, 1'b0);
        run_load(1'b1, 16'h8100, 6'd20, 7'd8, BYTE2_RDC, 0, 1'b0);
        run_load(1'b0, 16'hD000, 6'd0,  7'd8, 0, BYTE2_RDC, 1'b0);

        // Reset and start in the same cycle: reset must win.
        @(posedge I_CLK); #1 I_RESET = 1'b1; I_START = 1'b1;
        @(posedge I_CLK); #1 I_RESET = 1'b0; I_START = 1'b0;
        @(negedge I_CLK);
        chk("rst_prio_busy", O_BUSY, 0);
        chk("rst_prio_req", O_BUS_REQ, 0);

        run_load(1'b0, 16'hA055, 6'd40, 7'd5, 0, 0, 1'b0);
        chk("err_none", O_ERR, 0);

`ifdef PALETTE_LOADER_VERIFY_EN
        corrupt_en = 1'b1;
        run_load(1'b0, 16'hC000, 6'd0, 7'd8, 0, 0, 1'b0);
        chk("err_set", O_ERR, 1);
        chk("err_idx", O_ERR_INDEX, 5);
        corrupt_en = 1'b0;
        run_load(1'b0, 16'hC100, 6'd0, 7'd2, 0, 0, 1'b0);
        chk("err_after", O_ERR, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
